// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction fetch controller: owns the PC, runs the req/ack handshake
// with instruction memory and presents one instruction at a time to decode.
module fetch_sequencer #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'hBFC00000
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             instr_valid,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_target,
    output logic [31:0]      retired_count
);

    typedef enum logic [1:0] {
        S_START,
        S_FETCH,
        S_FLUSH,
        S_HOLD
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_nxt;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_instr;
    logic [WIDTH-1:0] w_instr_nxt;
    logic [WIDTH-1:0] r_instr_pc;
    logic [WIDTH-1:0] w_instr_pc_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic [31:0]      r_retired;
    logic [31:0]      w_retired_nxt;
    logic [WIDTH-1:0] w_target;

    assign w_target = redirect_target & ~WIDTH'(3);

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_instr_nxt    = r_instr;
        w_instr_pc_nxt = r_instr_pc;
        w_valid_nxt    = r_valid;
        w_retired_nxt  = r_retired;
        unique case (r_state)
            S_START: begin
                w_state_nxt = S_FETCH;
                if (redirect) w_pc_nxt = w_target;
            end
            S_FETCH: begin
                if (redirect) begin
                    w_pc_nxt    = w_target;
                    // An ack in the redirect cycle closes the old request, so refetch at once.
                    w_state_nxt = mem_ack ? S_FETCH : S_FLUSH;
                end else if (mem_ack) begin
                    w_instr_nxt    = mem_rdata;
                    w_instr_pc_nxt = r_pc;
                    w_valid_nxt    = 1'b1;
                    w_state_nxt    = S_HOLD;
                end
            end
            S_FLUSH: begin
                if (redirect) w_pc_nxt = w_target;
                if (mem_ack) w_state_nxt = S_FETCH;
            end
            S_HOLD: begin
                if (!stall) w_retired_nxt = r_retired + 32'd1;
                if (redirect) begin
                    w_valid_nxt = 1'b0;
                    w_pc_nxt    = w_target;
                    w_state_nxt = S_FETCH;
                end else if (!stall) begin
                    w_valid_nxt = 1'b0;
                    w_pc_nxt    = r_pc + WIDTH'(4);
                    w_state_nxt = S_FETCH;
                end
            end
            default: w_state_nxt = S_START;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_START;
            r_pc       <= RESET_PC;
            r_addr     <= RESET_PC;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_valid    <= 1'b0;
            r_retired  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_instr    <= w_instr_nxt;
            r_instr_pc <= w_instr_pc_nxt;
            r_valid    <= w_valid_nxt;
            r_retired  <= w_retired_nxt;
            // Address only moves when a fresh request starts; FLUSH keeps the squashed one.
            if (w_state_nxt == S_FETCH) r_addr <= w_pc_nxt;
        end
    end

    assign mem_req       = (r_state == S_FETCH) || (r_state == S_FLUSH);
    assign mem_addr      = r_addr;
    assign instr_valid   = r_valid;
    assign instr         = r_instr;
    assign instr_pc      = r_instr_pc;
    assign retired_count = r_retired;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: random memory latency, stalls and redirects
// against an architectural-PC reference model.
module tb_fetch_sequencer;

    localparam logic [31:0] RPC = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = '0;
    logic [31:0] retired_count;

    fetch_sequencer #(.WIDTH(32), .RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .stall(stall), .redirect(redirect), .redirect_target(redirect_target),
        .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference model: architectural PC, expected deliveries, consumed count.
    logic [31:0] exp_q[$];
    logic [31:0] arch_pc;
    logic [31:0] ret_exp;

    // Stimulus knobs and memory responder state.
    int          fix_lat   = -1;
    int unsigned stall_pct = 0;
    int unsigned redir_pct = 0;
    bit          spur      = 1'b0;
    int unsigned inj_mode  = 0;
    logic [31:0] inj_tgt   = '0;
    bit          in_req    = 1'b0;
    int          lat       = 0;
    int          wt        = 0;
    logic [31:0] req_addr  = '0;
    bit          last_ack  = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h3C1D0F5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 3))
            0:       return 32'hFFFFFFFC;
            1:       return 32'h00000040;
            2:       return RPC + ($urandom_range(0, 63) << 2) + $urandom_range(0, 3);
            default: return $urandom;
        endcase
    endfunction

    task automatic model_reset();
        arch_pc = RPC;
        exp_q.delete();
        exp_q.push_back(RPC);
        ret_exp  = '0;
        in_req   = 1'b0;
        last_ack = 1'b0;
        mem_ack  = 1'b0;
        stall    = 1'b0;
        redirect = 1'b0;
    endtask

    // One cycle of stimulus, applied at the falling edge for the next rising edge.
    task automatic drive_cycle();
        bit consume;
        @(negedge clk);
        mem_ack = 1'b0;
        if (mem_req) begin
            if (!in_req) begin
                in_req   = 1'b1;
                wt       = 0;
                lat      = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 3));
                req_addr = mem_addr;
            end else begin
                check("addr_stable", mem_addr, req_addr);
            end
            if (wt == lat) begin
                mem_ack = 1'b1;
                in_req  = 1'b0;
            end else begin
                wt++;
            end
        end else begin
            in_req = 1'b0;
            if (spur && $urandom_range(0, 7) == 0) mem_ack = 1'b1;
        end
        mem_rdata = (mem_ack && mem_req) ? mem_word(mem_addr) : $urandom;
        last_ack  = mem_ack && mem_req;

        stall           = ($urandom_range(0, 99) < stall_pct);
        redirect        = ($urandom_range(0, 99) < redir_pct);
        redirect_target = pick_target();
        if (inj_mode == 1 || (inj_mode == 2 && instr_valid)) begin
            redirect        = 1'b1;
            redirect_target = inj_tgt;
            stall           = 1'b0;
            inj_mode        = 0;
        end

        consume = instr_valid && !stall;
        if (consume) ret_exp = ret_exp + 32'd1;
        if (redirect) begin
            arch_pc = redirect_target & ~32'd3;
            exp_q.delete();
            exp_q.push_back(arch_pc);
        end else if (consume) begin
            arch_pc = arch_pc + 32'd4;
            exp_q.push_back(arch_pc);
        end
    endtask

    task automatic do_reset(input bit check_now);
        rst_n = 1'b0;
        #1;
        if (check_now) begin
            check("rst_mem_req", {31'b0, mem_req}, 32'd0);
            check("rst_valid", {31'b0, instr_valid}, 32'd0);
            check("rst_instr", instr, 32'd0);
            check("rst_instr_pc", instr_pc, 32'd0);
            check("rst_retired", retired_count, 32'd0);
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_req", {31'b0, mem_req}, 32'd1);
        check("first_addr", mem_addr, RPC);
    endtask

    task automatic run_until_injected();
        for (int i = 0; i < 60 && inj_mode != 0; i++) drive_cycle();
        if (inj_mode != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL inject_timeout: redirect not applied, mode %0d", inj_mode);
            inj_mode = 0;
        end
    endtask

    // Monitor: pops the scoreboard whenever a new instruction is presented.
    initial begin
        bit          prev_valid;
        logic [31:0] held_instr;
        logic [31:0] held_pc;
        logic [31:0] e;
        prev_valid = 1'b0;
        held_instr = '0;
        held_pc    = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                prev_valid = 1'b0;
                continue;
            end
            if (instr_valid && !prev_valid) begin
                check("valid_after_ack", {31'b0, last_ack}, 32'd1);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_instr: got pc %h, none expected", instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("instr_pc", instr_pc, e);
                    check("instr", instr, mem_word(e));
                end
            end
            if (instr_valid && prev_valid) begin
                check("hold_instr", instr, held_instr);
                check("hold_pc", instr_pc, held_pc);
            end
            if (instr_valid) check("no_req_in_hold", {31'b0, mem_req}, 32'd0);
            check("retired", retired_count, ret_exp);
            prev_valid = instr_valid;
            held_instr = instr;
            held_pc    = instr_pc;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        // Best-case throughput: ack in first request cycle, never stalled.
        fix_lat = 0;
        do_reset(1'b1);
        repeat (6) drive_cycle();
        @(posedge clk);
        #1;
        check("seq_retired", retired_count, 32'd3);

        // Wait states and stalls.
        fix_lat   = 3;
        stall_pct = 60;
        repeat (200) drive_cycle();

        // Redirect in the first FETCH cycle before ack: data must be squashed.
        stall_pct = 0;
        begin
            int i;
            for (i = 0; i < 40; i++) begin
                drive_cycle();
                if (instr_valid) break;
            end
            if (!instr_valid) begin
                n_tests++;
                n_fail++;
                $display("FAIL wait_valid: no instruction within 40 cycles");
            end
        end
        inj_mode = 1;
        inj_tgt  = 32'hBFC00103;
        drive_cycle();
        repeat (30) drive_cycle();

        // Redirect with consumption in HOLD, then wrap from the top of memory.
        fix_lat  = -1;
        inj_mode = 2;
        inj_tgt  = 32'h00000040;
        run_until_injected();
        repeat (20) drive_cycle();
        inj_mode = 2;
        inj_tgt  = 32'hFFFFFFFC;
        run_until_injected();
        repeat (30) drive_cycle();

        // Random traffic with spurious acks.
        stall_pct = 30;
        redir_pct = 10;
        spur      = 1'b1;
        repeat (1500) drive_cycle();

        // Reset in the middle of a pending fetch.
        fix_lat = 3;
        begin
            int i;
            for (i = 0; i < 40; i++) begin
                drive_cycle();
                if (mem_req) break;
            end
            if (!mem_req) begin
                n_tests++;
                n_fail++;
                $display("FAIL wait_req: no request within 40 cycles");
            end
        end
        #2;
        do_reset(1'b1);
        fix_lat = -1;
        repeat (400) drive_cycle();

        @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
